fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage that drives the IF/ID pipeline register. It holds the program counter, presents the fetch address to instruction memory, and returns `InstrF`, `PCF` and `PCPlus4F` to IF/ID. Next-PC selection is predicted by a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The execute stage corrects mispredictions and trains the table; the hazard unit freezes fetch through `stall_f`, in lock-step with `stall_d` on IF/ID.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `BTB_IDX`, default 4: index width; the table has 2^BTB_IDX entries.

Ports:
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `stall_f`  in  1: hold PC; outputs stay stable.
- `imem_addr`  out  32: fetch address, equal to `PCF`.
- `imem_rdata`  in  32: combinational instruction-memory read data.
- `InstrF`  out  32: equal to `imem_rdata`.
- `PCF`  out  32: current PC register.
- `PCPlus4F`  out  32: `PCF + 4`, modulo 2^32.
- `pred_takenF`  out  1: fetch predicted this instruction taken.
- `pred_targetF`  out  32: predicted target; equals `PCPlus4F` when not taken.
- `redirect_e`  in  1: misprediction or jalr correction from execute.
- `redirect_pc_e`  in  32: correct next PC.
- `update_e`  in  1: resolved branch or jump in execute; train the table.
- `update_pc_e`  in  32: PC of the resolved instruction.
- `update_taken_e`  in  1: resolved direction.
- `update_target_e`  in  32: resolved target.

## Operation
- PC register is reset to `RESET_PC`.
- BTB entry fields: `valid` (1 bit), `tag` = PC[31:BTB_IDX+2], `target` (32 bits), `ctr` (2 bits).
- Lookup index is PCF[BTB_IDX+1:2].
- Hit: `valid` is set and `tag` matches.
- Prediction: `pred_takenF` = hit and `ctr[1]`; `pred_targetF` = hit ? `target` : `PCPlus4F`.
- Next-PC priority, highest first:
  - `reset`: `RESET_PC`.
  - `redirect_e`: `redirect_pc_e`. Redirect wins over `stall_f`.
  - `stall_f`: PC unchanged.
  - `pred_takenF`: `pred_targetF`.
  - otherwise `PCPlus4F`.
- Training when `update_e` is high; index and tag are taken from `update_pc_e`.
  - Hit and taken: `ctr` increments, saturating at 2'b11; `target` <= `update_target_e`.
  - Hit and not taken: `ctr` decrements, saturating at 2'b00.
  - Miss and taken: allocate the entry with `valid`=1, new tag, `target` = `update_target_e`, `ctr` = 2'b10. Any previous occupant is overwritten.
  - Miss and not taken: no change.
- Training is independent of `stall_f` and `redirect_e`.
- PC bits [1:0] are not checked. Misaligned targets propagate unchanged.

## Timing
- Fetch outputs are combinational from the PC register and BTB contents (plus `imem_rdata`). Zero-cycle lookup.
- PC and BTB update on the rising edge only.
- Asynchronous reset, effective immediately while asserted:
  - PC = `RESET_PC`.
  - All `valid` = 0; all `ctr` = 2'b01.
  - Tags and targets don't-care.
  - Outputs settle to `PCF` = `RESET_PC`, `PCPlus4F` = `RESET_PC`+4, `pred_takenF` = 0, `pred_targetF` = `RESET_PC`+4.
- Reset mid-operation discards any pending redirect or update.
- First fetch after reset release is from `RESET_PC` in that cycle.
- Redirect latency: `redirect_e` high in cycle N gives `PCF` = `redirect_pc_e` in cycle N+1. Squashing wrong-path instructions in IF/ID and ID/EX is the hazard unit's job.
- Update and lookup to the same index in the same cycle: the lookup uses the pre-update entry. The new value is visible from the next cycle.
- Stall: `PCF`, `InstrF` (given stable memory), `pred_takenF` and `pred_targetF` are held for every stalled cycle. A training write in a stalled cycle may change the prediction in the following cycle. This is permitted and consistent with IF/ID holding its own copy.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Test plan
- Reset with `RESET_PC`=0, no stalls, empty BTB: `PCF` sequence 0, 4, 8, 12; `pred_takenF`=0 throughout.
- `stall_f` high for 3 cycles at `PCF`=8: `PCF` stays 8 for 3 cycles, then 12; `InstrF` stable while stalled.
- `update_e` at `update_pc_e`=0x10, taken, target 0x40: next visit to `PCF`=0x10 gives `pred_takenF`=1, `pred_targetF`=0x40, next `PCF`=0x40.
- Same entry trained not-taken twice (`ctr` 10→01→00): `pred_takenF`=0 at 0x10; one further taken update (`ctr`=01) still predicts not-taken.
- `redirect_e`=1 with `redirect_pc_e`=0x80 while `stall_f`=1: next `PCF`=0x80.
- Assert `reset` asynchronously mid-run with an allocated entry: `PCF` goes to `RESET_PC` before the next clock edge; a revisit of 0x10 predicts not-taken.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register with next-PC prediction from a
// direct-mapped BTB of 2-bit saturating counters, trained from execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned BTB_IDX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        pred_takenF,
  output logic [31:0] pred_targetF,
  input  logic        redirect_e,
  input  logic [31:0] redirect_pc_e,
  input  logic        update_e,
  input  logic [31:0] update_pc_e,
  input  logic        update_taken_e,
  input  logic [31:0] update_target_e
);
  localparam int unsigned ENTRIES = 2 ** BTB_IDX;
  localparam int unsigned TAG_W   = 32 - BTB_IDX - 2;

  logic [31:0]        pc_q, pc_d;
  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d;

  logic [BTB_IDX-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]   f_tag, u_tag;
  logic               f_hit, u_hit;
  logic               unused_upd_lsbs;

  assign f_idx = pc_q[BTB_IDX+1:2];
  assign f_tag = pc_q[31:BTB_IDX+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign u_idx = update_pc_e[BTB_IDX+1:2];
  assign u_tag = update_pc_e[31:BTB_IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign unused_upd_lsbs = ^update_pc_e[1:0];

  assign PCF          = pc_q;
  assign imem_addr    = pc_q;
  assign InstrF       = imem_rdata;
  assign PCPlus4F     = pc_q + 32'd4;
  assign pred_takenF  = f_hit & ctr_q[f_idx][1];
  assign pred_targetF = f_hit ? target_q[f_idx] : PCPlus4F;

  always_comb begin
    pc_d = PCPlus4F;
    if (redirect_e)       pc_d = redirect_pc_e;
    else if (stall_f)     pc_d = pc_q;
    else if (pred_takenF) pc_d = pred_targetF;
  end

  // A miss that reaches the write below is always a taken allocation.
  always_comb begin
    ctr_d = 2'b10;
    if (u_hit) begin
      ctr_d = ctr_q[u_idx];
      if (update_taken_e && ctr_q[u_idx] != 2'b11)       ctr_d = ctr_q[u_idx] + 2'd1;
      else if (!update_taken_e && ctr_q[u_idx] != 2'b00) ctr_d = ctr_q[u_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      if (update_e && (u_hit || update_taken_e)) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= ctr_d;
      end
    end
  end

  // Tag/target need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (update_e && update_taken_e) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= update_target_e;
    end
  end
endmodule
